temporal_encoder: RTL

- Upstream stage of the space-time comparator network (less-than-equal and similar race-logic cells).
- Converts a vector of binary values into edge/pulse-coded spikes inside one gamma cycle.
- Drives the per-gamma `rst` that clears downstream SR latches.
- Value v becomes a spike starting v cycles after the gamma window opens; null means "no spike" (infinity).

---
 rtl/temporal_encoder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/temporal_encoder.sv
// temporal_encoder: turns a vector of binary values into race-logic spikes inside one gamma window.
// Build option: define FALLING_ENC_EN for falling-edge encoding (default build is pulse-width encoding).
`timescale 1ns/1ps
module temporal_encoder #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int N_CH              = 2,
  parameter int VAL_W             = $clog2(GAMMA_CYCLE_WIDTH)
) (
  input  logic                   aclk,
  input  logic                   grst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_CH*VAL_W-1:0]  in_data,
  input  logic [N_CH-1:0]        in_null,
  output logic [N_CH-1:0]        spike,
  output logic                   gamma_rst,
  output logic                   busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam logic [VAL_W-1:0] T_LAST = VAL_W'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [VAL_W-1:0] T_ONE  = VAL_W'(1);
`ifndef FALLING_ENC_EN
  localparam logic [VAL_W-1:0] CLAMP_MAX = VAL_W'(GAMMA_CYCLE_WIDTH - PULSE_WIDTH);
  localparam logic [VAL_W:0]   PW_X      = (VAL_W+1)'(PULSE_WIDTH);
`endif

  // Value stored into the active register; pulses are clamped so they never cross the window end.
  function automatic logic [VAL_W-1:0] load_val(input logic [VAL_W-1:0] v);
`ifdef FALLING_ENC_EN
    load_val = v;
`else
    if (v > CLAMP_MAX) load_val = CLAMP_MAX;
    else               load_val = v;
`endif
  endfunction

  function automatic logic spike_bit(input logic [VAL_W-1:0] v, input logic nul,
                                     input logic [VAL_W-1:0] t);
`ifdef FALLING_ENC_EN
    spike_bit = nul | (t < v);
`else
    spike_bit = !nul && ({1'b0, t} >= {1'b0, v}) && ({1'b0, t} < ({1'b0, v} + PW_X));
`endif
  endfunction

  state_t                  state_r, state_nxt_s;
  logic [VAL_W-1:0]        t_r, t_nxt_s;
  logic [N_CH*VAL_W-1:0]   next_data_r, act_data_r, act_load_s;
  logic [N_CH-1:0]         next_null_r, act_null_r;
  logic                    next_valid_r;
  logic                    accept_s, load_s;
  logic [N_CH-1:0]         spike_r, spike_nxt_s;
  logic                    gamma_rst_r, busy_r;

  assign in_ready  = !next_valid_r;
  assign accept_s  = in_valid & !next_valid_r;
  assign spike     = spike_r;
  assign gamma_rst = gamma_rst_r;
  assign busy      = busy_r;

  // State register plus registered outputs derived from the upcoming state.
  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      state_r     <= ST_IDLE;
      t_r         <= {VAL_W{1'b0}};
      spike_r     <= {N_CH{1'b0}};
      gamma_rst_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      t_r         <= t_nxt_s;
      spike_r     <= spike_nxt_s;
      gamma_rst_r <= (state_nxt_s == ST_RESET);
      busy_r      <= (state_nxt_s != ST_IDLE);
    end
  end

  // Next-state and window counter; load_s marks the next->active hand-over.
  always_comb begin
    state_nxt_s = state_r;
    t_nxt_s     = t_r;
    load_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        t_nxt_s = {VAL_W{1'b0}};
        if (next_valid_r) begin
          state_nxt_s = ST_RESET;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RESET: begin
        state_nxt_s = ST_RUN;
        t_nxt_s     = {VAL_W{1'b0}};
      end
      ST_RUN: begin
        if (t_r == T_LAST) begin
          t_nxt_s = {VAL_W{1'b0}};
          if (next_valid_r) begin
            state_nxt_s = ST_RESET;
            load_s      = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          t_nxt_s = t_r + T_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        t_nxt_s     = {VAL_W{1'b0}};
      end
    endcase
  end

  // Spike levels for the upcoming cycle; only RUN cycles may carry a spike.
  always_comb begin
    spike_nxt_s = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      if (state_nxt_s == ST_RUN) begin
        spike_nxt_s[i] = spike_bit(act_data_r[i*VAL_W +: VAL_W], act_null_r[i], t_nxt_s);
      end else begin
        spike_nxt_s[i] = 1'b0;
      end
    end
  end

  // Per-channel value as it enters the active register.
  always_comb begin
    act_load_s = {(N_CH*VAL_W){1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      act_load_s[i*VAL_W +: VAL_W] = load_val(next_data_r[i*VAL_W +: VAL_W]);
    end
  end

  // Next/active vector buffers; an accept always wins over the hand-over clear.
  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      next_data_r  <= {(N_CH*VAL_W){1'b0}};
      next_null_r  <= {N_CH{1'b0}};
      next_valid_r <= 1'b0;
      act_data_r   <= {(N_CH*VAL_W){1'b0}};
      act_null_r   <= {N_CH{1'b0}};
    end else begin
      if (load_s) begin
        act_data_r <= act_load_s;
        act_null_r <= next_null_r;
      end
      if (accept_s) begin
        next_data_r  <= in_data;
        next_null_r  <= in_null;
        next_valid_r <= 1'b1;
      end else if (load_s) begin
        next_valid_r <= 1'b0;
      end
    end
  end

endmodule
